// File: rtl/peres_pkg.sv
// rtl/peres_pkg.sv - shared FSM state type and default sizing for peres_accum
package peres_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int NUM_OPS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/peres_full_adder.sv
// rtl/peres_full_adder.sv - reversible full adder built from two cascaded Peres gates
module peres_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic axb;
    logic ab;
    logic unused_g1;
    logic unused_g2;

    // First gate has its target tied low so r becomes a&b.
    peres_gate u_p1 (
        .a (a),
        .b (b),
        .c (1'b0),
        .p (unused_g1),
        .q (axb),
        .r (ab)
    );

    peres_gate u_p2 (
        .a (axb),
        .b (cin),
        .c (ab),
        .p (unused_g2),
        .q (sum),
        .r (cout)
    );

endmodule

// File: rtl/peres_gate.sv
// rtl/peres_gate.sv - 3x3 reversible Peres gate: p=a, q=a^b, r=(a&b)^c
module peres_gate (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic q,
    output logic r
);

    assign p = a;
    assign q = a ^ b;
    assign r = (a & b) ^ c;

endmodule

// File: rtl/peres_accum.sv
// rtl/peres_accum.sv - framed operand accumulator on a Peres ripple adder; PERES_ACCUM_SAT_EN selects saturation
module peres_accum
    import peres_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             overflow,
    output logic [7:0]       op_count
);

    localparam logic [7:0] LAST_CNT = 8'(NUM_OPS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [7:0]       cnt_inc;
    logic             xfer;

    assign carry[0] = 1'b0;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_fa
        peres_full_adder u_fa (
            .a    (acc_q[i]),
            .b    (in_data[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign op_count  = cnt_q;

    assign xfer    = in_valid && in_ready;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        acc_d   = in_data;
                        ovf_d   = 1'b0;
                        cnt_d   = 8'd1;
                        state_d = (NUM_OPS == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
`ifdef PERES_ACCUM_SAT_EN
                        acc_d = carry[WIDTH] ? '1 : sum;
`else
                        acc_d = sum;
`endif
                        ovf_d = ovf_q | carry[WIDTH];
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // Result registers stay frozen; only the handshake leaves DONE.
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
